// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, sizes and FSM encoding for the block data memory
package dmem_pkg;
  localparam int BLOCK_ADDR_W = 6;
  localparam int BLOCK_W = 32;
  localparam int NUM_BLOCKS = 64;
  localparam int CNT_W = 4;
  localparam int DEFAULT_LATENCY = 5;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/dmem_latency_counter.sv
// dmem_latency_counter: counts service edges, flags when LATENCY is reached
module dmem_latency_counter
  import dmem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic inc,
  output logic tc
);
  logic [CNT_W-1:0] count;
  // load starts a transaction at 1, inc advances while in service
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count <= '0;
    else count <= load ? CNT_W'(1) : inc ? count + CNT_W'(1) : count;
  end
  assign tc = count == CNT_W'(LATENCY);
endmodule

// File: rtl/block_data_memory.sv
// block_data_memory: 64 x 32-bit block memory answering the data cache with a fixed-latency busywait
module block_data_memory
  import dmem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int NUM_BLOCKS = dmem_pkg::NUM_BLOCKS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_ADDR_W-1:0] mem_address,
  input  logic [BLOCK_W-1:0]      mem_writedata,
  output logic [BLOCK_W-1:0]      mem_readdata,
  output logic                    mem_busywait
);
  state_t state;
  logic req, tc, wr_q;
  logic [BLOCK_ADDR_W-1:0] addr_q;
  logic [BLOCK_W-1:0] data_q;
  logic [BLOCK_W-1:0] mem [NUM_BLOCKS];
  assign req = mem_read | mem_write;
  assign mem_busywait = !reset && (state == BUSY || (state == IDLE && req));
  dmem_latency_counter #(.LATENCY(LATENCY)) u_cnt (
    .clock(clock),
    .reset(reset),
    .load (state == IDLE && req),
    .inc  (state == BUSY && !tc),
    .tc   (tc)
  );
  // accept a request in IDLE, complete the latched op at terminal count, hold DONE one cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wr_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      mem_readdata <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          addr_q <= mem_address;
          data_q <= mem_writedata;
          wr_q <= mem_write;
          state <= BUSY;
        end
        BUSY: if (tc) begin
          if (wr_q) mem[addr_q] <= data_q;
          else mem_readdata <= mem[addr_q];
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_block_data_memory.sv
// tb_block_data_memory: randomized and directed checks of both a LATENCY=5 and a LATENCY=1 memory
module tb_block_data_memory;
  logic clock = 0, reset = 1, rd = 0, wr = 0, sel = 0;
  logic [5:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata5, rdata1;
  logic bw5, bw1;
  logic [31:0] mdl [2][64];
  logic [31:0] rdm [2];
  int vectors = 0, miscompares = 0;

  always #5 clock = ~clock;

  block_data_memory #(.LATENCY(5)) dut5 (
    .clock(clock), .reset(reset), .mem_read(rd & ~sel), .mem_write(wr & ~sel),
    .mem_address(addr), .mem_writedata(wdata), .mem_readdata(rdata5), .mem_busywait(bw5));
  block_data_memory #(.LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .mem_read(rd & sel), .mem_write(wr & sel),
    .mem_address(addr), .mem_writedata(wdata), .mem_readdata(rdata1), .mem_busywait(bw1));

  wire bw = sel ? bw1 : bw5;
  wire [31:0] rdata = sel ? rdata1 : rdata5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int m = 0; m < 2; m++) begin
      rdm[m] = '0;
      for (int i = 0; i < 64; i++) mdl[m][i] = '0;
    end
  endtask

  task automatic op(input bit r, input bit w, input logic [5:0] a, input logic [31:0] d,
                    input int chg, input logic [5:0] a2);
    int n;
    @(negedge clock);
    rd = r; wr = w; addr = a; wdata = d;
    #1 check("bw_req", {31'b0, bw}, {31'b0, r | w});
    @(posedge clock); #1;
    n = 0;
    while (bw && n < 64) begin
      @(posedge clock); #1;
      n++;
      if (n == chg) begin
        addr = a2; wr = 0; wdata = ~d;
      end
    end
    check("latency", n, sel ? 1 : 5);
    if (w) mdl[sel][a] = d;
    else if (r) rdm[sel] = mdl[sel][a];
    check("rdata", rdata, rdm[sel]);
    rd = 0; wr = 0;
    @(posedge clock); #1;
    check("idle_bw", {31'b0, bw}, 32'h0);
  endtask

  task automatic rd_chk(input logic [5:0] a);
    op(1, 0, a, $urandom, 0, 0);
  endtask

  initial begin
    clear_model();
    repeat (2) @(posedge clock);
    #1 check("reset_bw", {31'b0, bw}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    @(negedge clock) reset = 0;
    rd_chk(6'h2A);
    op(0, 1, 6'h05, 32'hDEAD_BEEF, 0, 0);
    rd_chk(6'h05);
    op(0, 1, 6'h07, 32'h0BAD_CAFE, 0, 0);
    op(0, 1, 6'h3F, 32'h1234_5678, 0, 0);
    rd_chk(6'h07);
    rd_chk(6'h3F);
    op(0, 1, 6'h11, 32'h1111_1111, 0, 0);
    op(0, 1, 6'h10, 32'hA5A5_A5A5, 2, 6'h11);
    rd_chk(6'h11);
    rd_chk(6'h10);
    op(1, 1, 6'h01, 32'hCAFE_F00D, 0, 0);
    rd_chk(6'h01);
    for (int i = 0; i < 30; i++) begin
      logic [5:0] a = 6'($urandom);
      if ($urandom_range(1)) op(0, 1, a, $urandom, 0, 0);
      else rd_chk(a);
    end
    @(negedge clock);
    wr = 1; addr = 6'h20; wdata = 32'hFFFF_FFFF;
    repeat (4) @(posedge clock);
    #1 reset = 1;
    wr = 0;
    #1 check("rst_mid_bw", {31'b0, bw}, 32'h0);
    check("rst_mid_rdata", rdata, 32'h0);
    clear_model();
    @(negedge clock) reset = 0;
    rd_chk(6'h20);
    sel = 1;
    op(0, 1, 6'h09, 32'h5555_AAAA, 0, 0);
    rd_chk(6'h09);
    op(1, 1, 6'h01, 32'hCAFE_F00D, 0, 0);
    rd_chk(6'h01);
    for (int i = 0; i < 10; i++) begin
      logic [5:0] a = 6'($urandom);
      if ($urandom_range(1)) op(0, 1, a, $urandom, 0, 0);
      else rd_chk(a);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/block_data_memory.md
Name: block_data_memory

Overview:
- Block-organised main data memory: the responder on the data-cache ↔ memory interface. Serves 32-bit block reads and write-backs issued by the data cache controller.
- Holds 64 blocks × 32 bits (256 bytes), addressed by 6-bit block address {tag,index}.
- Fixed-latency busywait handshake: the cache holds its request until busywait falls, then advances its FSM.

Parameters:
- LATENCY, 5, clock edges from request acceptance to completion (legal range 1..15).
- NUM_BLOCKS, 64, number of 32-bit blocks (must equal 2**6).

Ports:
- clock  input  1  system clock, all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- mem_read  input  1  block read request, held by cache until busywait low.
- mem_write  input  1  block write request, held by cache until busywait low.
- mem_address  input  6  block address {tag[2:0],index[2:0]}.
- mem_writedata  input  32  write-back block; byte k of block = bits [8k+7:8k].
- mem_readdata  output  32  read block, registered.
- mem_busywait  output  1  high while a request is pending or in service.

Behaviour:
- Reset (async, any time): state=IDLE, counter=0, mem_readdata=0, all 64 blocks=0. mem_busywait=0 while reset is high. An in-flight write is not committed.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE:
  - mem_busywait = mem_read | mem_write, combinational, same cycle as the request.
  - posedge with a request: latch address, writedata and op; counter=1; go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mem_busywait=1.
  - Each posedge: if counter==LATENCY, complete the op and go to DONE; else counter+1.
  - Read completion: mem_readdata <= mem[addr_latched].
  - Write completion: mem[addr_latched] <= data_latched; mem_readdata unchanged.
- DONE:
  - mem_busywait=0 for exactly one cycle; mem_readdata held.
  - Request inputs ignored (the cache samples !busywait on this edge and drops the request).
  - Next posedge: go to IDLE unconditionally.
- Timing: request accepted at edge E0; completion at edge E_LATENCY; busywait low during cycle E_LATENCY..E_LATENCY+1; busywait is re-asserted earliest in the cycle after E_LATENCY+1.
- mem_readdata stays valid and stable from the completion edge until the next read completion or reset.
- Inputs changing or dropping while in BUSY: ignored. The latched op still completes, so no partial write occurs.
- mem_read and mem_write both high at acceptance: write wins; no read data update.
- Back-to-back operations (write-back then fetch): the second request is accepted from IDLE as a new transaction with full LATENCY.
- LATENCY=1: BUSY lasts one edge; DONE follows on the next edge.
- Address wrap: none. All 6-bit addresses are valid; no out-of-range case.

Decomposition:
- Package dmem_pkg holds:
  - BLOCK_ADDR_W=6, BLOCK_W=32, NUM_BLOCKS=64.
  - State encodings IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - Default LATENCY.
- One sub-module is natural: dmem_latency_counter (load-to-1, increment, terminal-count flag at LATENCY, async reset).
- The storage array and FSM stay in the top module.

Test Plan:
- Reset then read addr 6'h2A → busywait high immediately, low after 5 edges; mem_readdata=32'h0000_0000.
- Write addr 6'h05 data 32'hDEAD_BEEF, then read 6'h05 → busywait 5 edges each; mem_readdata=32'hDEAD_BEEF after the read completes; DONE cycle visible between the two transactions.
- Write-back 6'h3F data 32'h1234_5678, then immediate fetch 6'h07 (cache miss sequence) → two separate 5-edge busy windows; mem[6'h3F]=32'h1234_5678; mem_readdata=mem[6'h07].
- Start write 6'h10 data 32'hA5A5_A5A5, change mem_address to 6'h11 and drop mem_write at edge 2 → block 6'h10 written, block 6'h11 unchanged, busywait still falls after edge 5.
- Start write 6'h20 data 32'hFFFF_FFFF, assert reset at edge 3 → busywait=0, state IDLE, mem_readdata=0; subsequent read 6'h20 returns 32'h0.
- mem_read and mem_write both high, addr 6'h01, data 32'hCAFE_F00D → block written, mem_readdata keeps its prior value; repeat the bench with LATENCY=1 → busywait high for exactly one edge.
